tia_pf_serializer: RTL and testbench

//  Single-clock synchronous model of the TIA playfield serializer. Holds PF0/PF1/PF2 and

---
 rtl/tia_pf_pkg.sv | 34 +++
 rtl/tia_pf_step_reg.sv | 25 ++
 rtl/tia_pf_serializer.sv | 115 +++++++++++
 tb/tb_tia_pf_serializer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tia_pf_pkg.sv
// Shared constants and helpers for the TIA playfield serializer: slot map and
// start-token decode.
package tia_pf_pkg;

  localparam int unsigned PF_SLOTS  = 20;
  localparam int unsigned CHAIN_LEN = PF_SLOTS - 1;

  typedef struct packed {
    logic rep;   // forward (repeat) chain start
    logic refl;  // backward (reflect) chain start
  } pf_start_t;

  // Slot k of the returned vector is the stored bit shown at screen slot Sk.
  // PF0 holds only d[7:4], so pf0[0] is PF0.4.
  function automatic logic [PF_SLOTS-1:0] pf_slot_map(input logic [3:0] pf0,
                                                      input logic [7:0] pf1,
                                                      input logic [7:0] pf2);
    logic [PF_SLOTS-1:0] s;
    s[3:0] = pf0;
    for (int i = 0; i < 8; i++) begin
      s[4 + i]  = pf1[7 - i];
      s[12 + i] = pf2[i];
    end
    return s;
  endfunction

  function automatic pf_start_t pf_start(input logic ref_bar, input logic cnt, input logic rhb);
    pf_start_t st;
    st.rep  = (ref_bar & cnt) | rhb;
    st.refl = ~ref_bar & cnt;
    return st;
  endfunction

endpackage

// File: rtl/tia_pf_step_reg.sv
// Step-enabled register with synchronous active-low reset; models one D1 stage
// per bit, advancing only on playfield steps.
module tia_pf_step_reg #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/tia_pf_serializer.sv
// TIA playfield serializer: PF0/PF1/PF2 registers, forward and backward position
// token chains over 20 slots, and the D1/F1 output path driving pf and cntd.
module tia_pf_serializer
  import tia_pf_pkg::*;
(
  input  logic       clkp,
  input  logic       reset_bar,
  input  logic       hstep,
  input  logic       cnt,
  input  logic       rhb,
  input  logic       ref_bar,
  input  logic [7:0] d,
  input  logic       pf0_wr,
  input  logic       pf1_wr,
  input  logic       pf2_wr,
  output logic       cntd,
  output logic       pf
);

  logic [3:0]          pf0_q;
  logic [7:0]          pf1_q;
  logic [7:0]          pf2_q;
  pf_start_t           start;
  logic [CHAIN_LEN:1]  f_q;
  logic [CHAIN_LEN:1]  f_d;
  logic [CHAIN_LEN:1]  b_q;
  logic [CHAIN_LEN:1]  b_d;
  logic [PF_SLOTS-1:0] slot_act;
  logic [PF_SLOTS-1:0] slot_bits;
  logic                pix;
  logic                pix_d_q;
  logic                pf_q;

  always_ff @(posedge clkp) begin
    if (!reset_bar) begin
      pf0_q <= '0;
      pf1_q <= '0;
      pf2_q <= '0;
    end else begin
      if (pf0_wr) pf0_q <= d[7:4];
      if (pf1_wr) pf1_q <= d;
      if (pf2_wr) pf2_q <= d;
    end
  end

  assign start = pf_start(ref_bar, cnt, rhb);
  assign f_d   = {f_q[CHAIN_LEN-1:1], start.rep};
  assign b_d   = {b_q[CHAIN_LEN-1:1], start.refl};

  tia_pf_step_reg #(
    .Width(CHAIN_LEN)
  ) u_fwd_chain (
    .clk_i (clkp),
    .rst_ni(reset_bar),
    .en_i  (hstep),
    .d_i   (f_d),
    .q_o   (f_q)
  );

  tia_pf_step_reg #(
    .Width(CHAIN_LEN)
  ) u_bwd_chain (
    .clk_i (clkp),
    .rst_ni(reset_bar),
    .en_i  (hstep),
    .d_i   (b_d),
    .q_o   (b_q)
  );

  // Edge slots are also lit combinationally by a start in progress; the
  // backward chain walks from S19 down, so b[k] lights S(19-k).
  always_comb begin
    slot_act              = '0;
    slot_act[0]           = start.rep | b_q[CHAIN_LEN];
    slot_act[PF_SLOTS-1]  = start.refl | f_q[CHAIN_LEN];
    for (int k = 1; k < CHAIN_LEN; k++) begin
      slot_act[k] = f_q[k] | b_q[CHAIN_LEN-k];
    end
  end

  assign slot_bits = pf_slot_map(pf0_q, pf1_q, pf2_q);
  assign pix       = |(slot_act & slot_bits);

  tia_pf_step_reg #(
    .Width(1)
  ) u_pix_d (
    .clk_i (clkp),
    .rst_ni(reset_bar),
    .en_i  (hstep),
    .d_i   (pix),
    .q_o   (pix_d_q)
  );

  tia_pf_step_reg #(
    .Width(1)
  ) u_cntd (
    .clk_i (clkp),
    .rst_ni(reset_bar),
    .en_i  (hstep),
    .d_i   (cnt),
    .q_o   (cntd)
  );

  // F1 stage: follows pix_d on every clock, not just on steps.
  always_ff @(posedge clkp) begin
    if (!reset_bar) begin
      pf_q <= 1'b0;
    end else begin
      pf_q <= pix_d_q;
    end
  end

  assign pf = pf_q;

endmodule

// File: tb/tb_tia_pf_serializer.sv
// Self-checking bench for tia_pf_serializer: table-driven single-token sweeps plus
// hand-written gapped-step, reset and write-timing sequences.
module tb_tia_pf_serializer;

  logic       clkp = 1'b0;
  logic       reset_bar = 1'b0;
  logic       hstep = 1'b0;
  logic       cnt = 1'b0;
  logic       rhb = 1'b0;
  logic       ref_bar = 1'b1;
  logic [7:0] d = 8'h00;
  logic       pf0_wr = 1'b0;
  logic       pf1_wr = 1'b0;
  logic       pf2_wr = 1'b0;
  logic       cntd;
  logic       pf;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_q[$];

  tia_pf_serializer dut (
    .clkp     (clkp),
    .reset_bar(reset_bar),
    .hstep    (hstep),
    .cnt      (cnt),
    .rhb      (rhb),
    .ref_bar  (ref_bar),
    .d        (d),
    .pf0_wr   (pf0_wr),
    .pf1_wr   (pf1_wr),
    .pf2_wr   (pf2_wr),
    .cntd     (cntd),
    .pf       (pf)
  );

  always #5 clkp = ~clkp;

  typedef struct {
    string       name;
    logic [7:0]  p0;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic        rb;
    logic        use_cnt;
    logic [19:0] exp;  // bit k = expected pixel for step k after the start
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_wr(input int sel, input logic [7:0] val);
    d      = val;
    pf0_wr = (sel == 0);
    pf1_wr = (sel == 1);
    pf2_wr = (sel == 2);
  endtask

  task automatic clr_drive();
    hstep  = 1'b0;
    rhb    = 1'b0;
    cnt    = 1'b0;
    pf0_wr = 1'b0;
    pf1_wr = 1'b0;
    pf2_wr = 1'b0;
  endtask

  // One playfield step; pf after this edge shows the previous step's pixel.
  task automatic do_step(input string name, input logic r, input logic c, input logic e,
                         input int wsel, input logic [7:0] wd);
    @(negedge clkp);
    hstep = 1'b1;
    rhb   = r;
    cnt   = c;
    set_wr(wsel, wd);
    @(posedge clkp);
    #1;
    clr_drive();
    if (exp_q.size() > 0) chk(name, pf, exp_q.pop_front());
    exp_q.push_back(e);
  endtask

  task automatic idle_chk(input string name, input logic exp_cntd);
    @(negedge clkp);
    clr_drive();
    @(posedge clkp);
    #1;
    if (exp_q.size() > 0) chk(name, pf, exp_q[$]);
    chk({name, "_cntd"}, cntd, exp_cntd);
  endtask

  task automatic flush(input string name);
    @(negedge clkp);
    clr_drive();
    @(posedge clkp);
    #1;
    while (exp_q.size() > 0) chk(name, pf, exp_q.pop_front());
  endtask

  task automatic write_reg(input int sel, input logic [7:0] val);
    @(negedge clkp);
    hstep = 1'b0;
    set_wr(sel, val);
    @(posedge clkp);
    #1;
    clr_drive();
  endtask

  task automatic load_regs(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
    write_reg(0, p0);
    write_reg(1, p1);
    write_reg(2, p2);
  endtask

  initial begin
    vecs[0] = '{"rep_pf0_4",  8'h10, 8'h00, 8'h00, 1'b1, 1'b0, 20'h00001};
    vecs[1] = '{"rep_pf1_7",  8'h00, 8'h80, 8'h00, 1'b1, 1'b1, 20'h00010};
    vecs[2] = '{"refl_pf2_7", 8'h00, 8'h00, 8'h80, 1'b0, 1'b1, 20'h00001};
    vecs[3] = '{"refl_pf0_4", 8'h10, 8'h00, 8'h00, 1'b0, 1'b1, 20'h80000};
    vecs[4] = '{"rep_all",    8'hF0, 8'hFF, 8'hFF, 1'b1, 1'b0, 20'hFFFFF};
    vecs[5] = '{"rep_pf2_0",  8'h00, 8'h00, 8'h01, 1'b1, 1'b1, 20'h01000};
    vecs[6] = '{"refl_pf1_0", 8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 20'h00100};
    vecs[7] = '{"rhb_in_ref", 8'h80, 8'h40, 8'h00, 1'b0, 1'b0, 20'h00028};

    // Reset state
    repeat (3) @(posedge clkp);
    #1;
    chk("reset_pf", pf, 1'b0);
    chk("reset_cntd", cntd, 1'b0);
    @(negedge clkp);
    reset_bar = 1'b1;

    // Single start pulse sweeps, 20 slots plus trailing empty steps
    foreach (vecs[v]) begin
      load_regs(vecs[v].p0, vecs[v].p1, vecs[v].p2);
      ref_bar = vecs[v].rb;
      for (int k = 0; k < 24; k++) begin
        do_step(vecs[v].name, (k == 0) && !vecs[v].use_cnt, (k == 0) && vecs[v].use_cnt,
                (k < 20) ? vecs[v].exp[k] : 1'b0, -1, 8'h00);
      end
      flush(vecs[v].name);
    end

    // Gapped steps: pf holds 4 clocks per step, cntd one step behind cnt
    load_regs(8'hF0, 8'h00, 8'h00);
    ref_bar = 1'b1;
    for (int k = 0; k < 8; k++) begin
      do_step("gap_step", 1'b0, k == 0, k < 4, -1, 8'h00);
      for (int j = 0; j < 3; j++) idle_chk("gap_hold", k == 0);
    end
    flush("gap_flush");

    // Reset mid-token: tokens lost, pf stays low without a new start
    load_regs(8'hFF, 8'hFF, 8'hFF);
    ref_bar = 1'b1;
    for (int k = 0; k < 3; k++) do_step("pre_rst", k == 0, 1'b0, 1'b1, -1, 8'h00);
    @(negedge clkp);
    reset_bar = 1'b0;
    hstep     = 1'b1;
    @(posedge clkp);
    #1;
    chk("mid_rst_pf", pf, 1'b0);
    chk("mid_rst_cntd", cntd, 1'b0);
    exp_q.delete();
    @(negedge clkp);
    reset_bar = 1'b1;
    hstep     = 1'b0;
    for (int k = 0; k < 6; k++) do_step("post_rst", 1'b0, 1'b0, 1'b0, -1, 8'h00);
    flush("post_rst");

    // Writes between steps and coincident with a step
    load_regs(8'hF0, 8'hFF, 8'h00);
    ref_bar = 1'b1;
    for (int k = 0; k < 5; k++) do_step("wr_pre", k == 0, 1'b0, 1'b1, -1, 8'h00);
    write_reg(1, 8'h00);
    do_step("wr_between", 1'b0, 1'b0, 1'b0, -1, 8'h00);   // S5 after clear
    do_step("wr_same_clk", 1'b0, 1'b0, 1'b0, 1, 8'hFF);  // S6 uses old PF1
    for (int k = 7; k < 20; k++) do_step("wr_post", 1'b0, 1'b0, k < 12, -1, 8'h00);
    do_step("wr_post", 1'b0, 1'b0, 1'b0, -1, 8'h00);
    flush("wr_post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
